dcache_port_ctrl: RTL
=====================

# dcache_port_ctrl

Single-ported data-memory controller directly downstream of `store_buffer_top`. It consumes the store buffer's drain requests (`stb2dcache_*`), serves LSU load requests, and returns a one-cycle ack with read data after a fixed, configurable access latency. It serialises stores and loads into one internal word array. Loads are held off while the store buffer is non-empty, so a load never reads stale data.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width
- `BYTE_SEL_WIDTH`, 4, byte enables; must equal `DATA_WIDTH/8`
- `DEPTH`, 256, words in the array; power of two
- `ACK_LAT`, 2, wait cycles before access; legal range 0..15

Ports. Clock is `clk`; reset is `rst`, asynchronous and active-high.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `stb2dcache_addr`  in  ADDR_WIDTH  store byte address
- `stb2dcache_wdata`  in  DATA_WIDTH  store data
- `stb2dcache_sel_byte`  in  BYTE_SEL_WIDTH  byte enables
- `stb2dcache_w_en`  in  1  1 = write, 0 = read through store port
- `stb2dcache_req`  in  1  store-port request; held until ack
- `stb2dcache_empty`  in  1  store buffer holds no entries
- `dmem_sel_i`  in  1  1 = target is this memory; 0 = ack without access
- `dcache2stb_ack`  out  1  one-cycle completion of store-port request
- `dcache2stb_rdata`  out  DATA_WIDTH  word after write, or read word
- `ld_req`  in  1  load request; held until ack
- `ld_addr`  in  ADDR_WIDTH  load byte address
- `ld_ack`  out  1  one-cycle load completion
- `ld_rdata`  out  DATA_WIDTH  load data
- `busy`  out  1  transaction in flight (state ≠ IDLE)

## Operation
- The array index is `addr[$clog2(DEPTH)+1:2]`. Bits [1:0] and the upper bits are ignored, so addresses alias modulo `DEPTH*4`.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- **IDLE**: on each edge, arbitrate.
  - If `stb2dcache_req` is high, grant the store port.
  - Otherwise, if `ld_req && stb2dcache_empty`, grant the load port.
  - Otherwise stay in IDLE.
  - On grant, latch the port, address, data, sel, w_en and dmem_sel, and load counter = `ACK_LAT`.
  - Go to WAIT if `ACK_LAT > 0`, else go to ACCESS.
- **WAIT**: decrement the counter. When the counter reaches 1, go to ACCESS. Request inputs are ignored; latched values are used.
- **ACCESS**: one cycle; the array is touched only on this edge.
  - Store port with w_en=1 and dmem_sel=1: for each i with sel[i]=1, write byte i. `dcache2stb_rdata` = the merged word.
  - Store port with w_en=0 and dmem_sel=1: `dcache2stb_rdata` = mem[idx].
  - dmem_sel=0: no array access; `dcache2stb_rdata` = 0.
  - Load port: `ld_rdata` = mem[idx].
  - The matching ack register is set. Go to RESP.
- **RESP**: the ack is high this cycle only. Clear the ack and go to IDLE.
- Store-port priority is absolute. A load waits for as long as stores are pending or `stb2dcache_empty` = 0.
- Each rdata holds its value until that port's next response.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset values: all acks 0, both rdata 0, `busy` 0, state IDLE, counter 0.
- Latency: the request is sampled at edge t0. The ack is high during the cycle following edge t0+`ACK_LAT`+1, i.e. `ACK_LAT`+2 edges after sampling. The ack is exactly 1 cycle wide.
- The requester drops req at the edge where it samples the ack. IDLE resamples one edge after RESP, so at least 1 idle cycle separates consecutive acks.
- `busy` = 1 from the edge after grant through the RESP cycle.
- Simultaneous store req and load req: the store is served first. The load is granted at the next IDLE edge in which no store req is pending and empty = 1.
- `stb2dcache_empty` falling after a load is granted has no effect on that load.
- Reset asserted in any state: immediate return to reset values and the in-flight transaction is discarded. There is no array write unless the ACCESS edge has already occurred.
- A req deasserted mid-transaction is not checked; the latched transaction completes.

## Test plan
- **Store then load.** Reset, `ACK_LAT`=2. Store 0x04 / 0xDEADBEEF / sel 4'b1111 / dmem_sel 1, then raise empty=1. Expect `dcache2stb_ack` exactly 4 edges after req is sampled, 1 cycle wide. Then load 0x04; expect `ld_ack` with `ld_rdata`=0xDEADBEEF.
- **Byte enables.** After the store above, store 0x04 / 0x11223344 / sel 4'b0101. Expect `dcache2stb_rdata`=0xDE22BE44, and a later load 0x04 returning 0xDE22BE44.
- **Load held off and priority.** Hold `ld_req` for 0x04 with empty=0 for 10 cycles; expect no `ld_ack`. Then raise `stb2dcache_req` and `ld_req` in the same cycle with empty set to 1 afterwards. Expect the store ack first, then the load ack at least `ACK_LAT`+3 edges later.
- **Non-memory target and aliasing.** Store with dmem_sel=0 to 0x08 / 0xFFFFFFFF: expect an ack with rdata 0 and a later load 0x08 unchanged. Store 0x400 / 0xA5A5A5A5 (`DEPTH`=256): expect a load 0x000 returning 0xA5A5A5A5.
- **Reset mid-WAIT.** Assert `rst` during WAIT of a store to 0x0C. Expect no ack, all outputs 0 and `busy`=0 while reset is high, and a later load 0x0C returning its previously written value.
- **Zero latency.** `ACK_LAT`=0: expect the ack 2 edges after req is sampled, and back-to-back stores acked every 3 cycles.

Source files
------------

// File: rtl/dcache_port_ctrl.sv
// dcache_port_ctrl: single-ported data-memory controller behind the store buffer.
// Serialises store-buffer drain requests and LSU loads into one word array and
// returns a one-cycle ack with read data after a fixed access latency.
//
// Handshake (both ports): the requester raises *_req with stable payload and
// holds it until it samples the matching *_ack high. The ack is exactly one
// cycle wide. Payload is latched at grant, so later changes to req or payload
// do not affect a transaction already in flight. Store port has absolute
// priority; loads are granted only while the store buffer reports empty.
module dcache_port_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int DEPTH          = 256,
    parameter int ACK_LAT        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_w_en,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_empty,
    input  logic                      dmem_sel_i,
    output logic                      dcache2stb_ack,
    output logic [DATA_WIDTH-1:0]     dcache2stb_rdata,
    input  logic                      ld_req,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    output logic                      ld_ack,
    output logic [DATA_WIDTH-1:0]     ld_rdata,
    output logic                      busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [3:0]                cnt_q;
    logic                      port_ld_q;
    logic                      w_en_q;
    logic                      dsel_q;
    logic [IDX_W-1:0]          idx_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [BYTE_SEL_WIDTH-1:0] sel_q;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [DATA_WIDTH-1:0]     mem_word;
    logic [DATA_WIDTH-1:0]     merged;

    logic grant_st;
    logic grant_ld;
    logic unused_addr_bits;

    // Address bits outside the word index are ignored, so addresses alias.
    assign unused_addr_bits = ^{stb2dcache_addr[ADDR_WIDTH-1:IDX_W+2], stb2dcache_addr[1:0],
                                ld_addr[ADDR_WIDTH-1:IDX_W+2], ld_addr[1:0]};

    assign grant_st = stb2dcache_req;
    assign grant_ld = !stb2dcache_req && ld_req && stb2dcache_empty;
    assign busy     = (state_q != S_IDLE);
    assign mem_word = mem[idx_q];

    // Byte-merge the latched store data over the current array word.
    always_comb begin
        merged = mem_word;
        for (int i = 0; i < BYTE_SEL_WIDTH; i++) begin
            if (sel_q[i]) begin
                merged[i*8 +: 8] = wdata_q[i*8 +: 8];
            end
        end
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate in IDLE, count down wait cycles, one access, one response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_st || grant_ld) begin
                    state_d = (ACK_LAT == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Latch the granted transaction and run the wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 4'd0;
            port_ld_q <= 1'b0;
            w_en_q    <= 1'b0;
            dsel_q    <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
        end else if (state_q == S_IDLE && (grant_st || grant_ld)) begin
            cnt_q     <= 4'(ACK_LAT);
            port_ld_q <= !grant_st;
            if (grant_st) begin
                w_en_q  <= stb2dcache_w_en;
                dsel_q  <= dmem_sel_i;
                idx_q   <= stb2dcache_addr[IDX_W+1:2];
                wdata_q <= stb2dcache_wdata;
                sel_q   <= stb2dcache_sel_byte;
            end else begin
                w_en_q  <= 1'b0;
                dsel_q  <= 1'b1;
                idx_q   <= ld_addr[IDX_W+1:2];
                wdata_q <= '0;
                sel_q   <= '0;
            end
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Acks pulse during RESP; read data is captured on the ACCESS edge and held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcache2stb_ack   <= 1'b0;
            dcache2stb_rdata <= '0;
            ld_ack           <= 1'b0;
            ld_rdata         <= '0;
        end else begin
            dcache2stb_ack <= (state_q == S_ACCESS) && !port_ld_q;
            ld_ack         <= (state_q == S_ACCESS) && port_ld_q;
            if (state_q == S_ACCESS) begin
                if (port_ld_q) begin
                    ld_rdata <= mem_word;
                end else if (!dsel_q) begin
                    dcache2stb_rdata <= '0;
                end else if (w_en_q) begin
                    dcache2stb_rdata <= merged;
                end else begin
                    dcache2stb_rdata <= mem_word;
                end
            end
        end
    end

    // Array write: only on the ACCESS edge of a selected store-port write.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && !port_ld_q && dsel_q && w_en_q) begin
            mem[idx_q] <= merged;
        end
    end

endmodule
